// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 port arbiter: FSM state encoding and the
// upper bound on the number of requesters.
package ddr3_arb_pkg;

    localparam int DDR3_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ddr3_port_arbiter_rr_picker.sv
// Combinational round-robin select: first set bit of elig_i scanning upward
// from last_i+1 (wrapping), returned as one-hot plus index.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        j     = 0;
        jj    = '0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // k = N revisits last_i itself, so a lone requester can win again
        for (int k = 1; k <= N; k++) begin
            j  = (int'(last_i) + k) % N;
            jj = j[IDX_W-1:0];
            if (!any_o && elig_i[jj]) begin
                any_o     = 1'b1;
                idx_o     = jj;
                gnt_o[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares one DDR3 controller port between NUM_REQ LSU requesters: round-robin
// grant, single-cycle command strobe, ready-edge completion with timeout abort.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0]        req_same_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        n_rdy_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      err_o,
    output logic                      ddr_en_o,
    output logic                      ddr_we_o,
    output logic [ADDR_W-1:0]         ddr_addr_o,
    output logic [DATA_W-1:0]         ddr_wdata_o,
    input  logic                      DDR3_rdy,
    input  logic                      DDR3_w_rdy,
    input  logic [DATA_W-1:0]         ddr_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                en_q, en_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rdy_pre_q, rdy_pre_d;
    logic                wrdy_pre_q, wrdy_pre_d;

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                ready_edge;

    // A requester whose done pulse is out this cycle must not be re-picked
    assign elig    = req_i & ~req_same_i & ~done_q;
    assign n_rdy_o = elig;

    rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .elig_i (elig),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    assign ready_edge = we_q ? (~wrdy_pre_q & DDR3_w_rdy) : (~rdy_pre_q & DDR3_rdy);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        done_d     = '0;
        en_d       = 1'b0;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        rdy_pre_d  = DDR3_rdy;
        wrdy_pre_d = DDR3_w_rdy;
        case (state_q)
            // DONE arbitrates like IDLE so back-to-back grants lose no cycle
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                if (pick_any) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_gnt;
                    last_d  = pick_idx;
                    we_d    = req_we_i[pick_idx];
                    addr_d  = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];
                end
            end
            ST_ISSUE: begin
                en_d    = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_edge) begin
                    state_d        = ST_DONE;
                    done_d[last_q] = 1'b1;
                    if (!we_q) rdata_d = ddr_rdata_i;
                end else if (cnt_q == CNT_LIM) begin
                    state_d        = ST_DONE;
                    done_d[last_q] = 1'b1;
                    err_d          = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            rdy_pre_q  <= 1'b1;
            wrdy_pre_q <= 1'b1;
        end else if (!stall_i) begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            last_q     <= last_d;
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            rdy_pre_q  <= rdy_pre_d;
            wrdy_pre_q <= wrdy_pre_d;
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign ddr_en_o    = en_q;
    assign ddr_we_o    = we_q;
    assign ddr_addr_o  = addr_q;
    assign ddr_wdata_o = wdata_q;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scenario bench for ddr3_port_arbiter; completions are checked against a
// queue of expected results filled as each request is driven.
module tb_ddr3_port_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset, stall_i;
    logic [NR-1:0]    req_i, req_we_i, req_same_i;
    logic [NR*AW-1:0] req_addr_i;
    logic [NR*DW-1:0] req_wdata_i;
    logic [NR-1:0]    grant_o, n_rdy_o, done_o;
    logic [DW-1:0]    rdata_o;
    logic             err_o, ddr_en_o, ddr_we_o;
    logic [AW-1:0]    ddr_addr_o;
    logic [DW-1:0]    ddr_wdata_o;
    logic             DDR3_rdy, DDR3_w_rdy;
    logic [DW-1:0]    ddr_rdata_i;

    ddr3_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i),
        .req_i(req_i), .req_we_i(req_we_i), .req_same_i(req_same_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .grant_o(grant_o), .n_rdy_o(n_rdy_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o),
        .ddr_en_o(ddr_en_o), .ddr_we_o(ddr_we_o),
        .ddr_addr_o(ddr_addr_o), .ddr_wdata_o(ddr_wdata_o),
        .DDR3_rdy(DDR3_rdy), .DDR3_w_rdy(DDR3_w_rdy), .ddr_rdata_i(ddr_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] done;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    int            en_cnt = 0;
    logic [NR-1:0] done_prev = '0;

    // Scoreboard: each new done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (ddr_en_o === 1'b1) en_cnt <= en_cnt + 1;
        if (done_o !== '0 && done_prev === '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: done=%b with nothing expected", done_o);
            end else begin
                mon_e = sb.pop_front();
                if (done_o !== mon_e.done || rdata_o !== mon_e.rdata || err_o !== mon_e.err) begin
                    errors++;
                    $display("FAIL sb_completion: got done=%b rdata=%h err=%b, want done=%b rdata=%h err=%b",
                             done_o, rdata_o, err_o, mon_e.done, mon_e.rdata, mon_e.err);
                end
            end
        end
        done_prev <= done_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [NR-1:0] d, input logic [DW-1:0] r, input logic e);
        exp_t x;
        x.done = d; x.rdata = r; x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ddr_en_o === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (done_o !== '0) ok = 1'b1;
        end
    endtask

    // DDR3 responder: on strobe, raise the matching ready dly cycles later
    task automatic serve(input int dly, input logic [DW-1:0] data, input bit hold,
                         output logic [NR-1:0] gnt, output logic [AW-1:0] addr,
                         output logic [NR-1:0] nrdy, output bit ok);
        logic [NR-1:0] d;
        gnt = '0; addr = '0; nrdy = '0; d = '0;
        wait_en(ok);
        if (!ok) return;
        gnt = grant_o; addr = ddr_addr_o; nrdy = n_rdy_o;
        repeat (dly) @(posedge clk);
        #1;
        if (ddr_we_o) DDR3_w_rdy = 1'b1;
        else begin DDR3_rdy = 1'b1; ddr_rdata_i = data; end
        wait_done(ok);
        d = done_o;
        step(1);
        DDR3_rdy = 1'b0; DDR3_w_rdy = 1'b0;
        if (!hold) req_i = req_i & ~d;
    endtask

    task automatic test_reset;
        reset = 1'b1; stall_i = 1'b0;
        req_i = '0; req_we_i = '0; req_same_i = '0; req_addr_i = '0; req_wdata_i = '0;
        DDR3_rdy = 1'b1; DDR3_w_rdy = 1'b1; ddr_rdata_i = '0;
        step(3);
        @(negedge clk);
        checks++;
        if ({grant_o, done_o, ddr_en_o, ddr_we_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: grant=%b done=%b en=%b we=%b err=%b, want all 0",
                     grant_o, done_o, ddr_en_o, ddr_we_o, err_o);
        end
        checks++;
        if (ddr_addr_o !== '0 || ddr_wdata_o !== '0 || rdata_o !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want 0", ddr_addr_o, ddr_wdata_o, rdata_o);
        end
        checks++;
        if (n_rdy_o !== '0) begin
            errors++;
            $display("FAIL reset_nrdy: got %b want 0000", n_rdy_o);
        end
        step(1);
        reset = 1'b0;
    endtask

    // Ready lines stay high out of reset: that level is not an edge
    task automatic test_held_ready;
        bit ok;
        req_addr_i[3*AW +: AW] = 32'h40;
        req_i = 4'b1000;
        wait_en(ok);
        checks++;
        if (!ok || grant_o !== 4'b1000 || ddr_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL held_issue: ok=%0d grant=%b addr=%h, want grant=1000 addr=40", ok, grant_o, ddr_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done_o !== '0) begin
                errors++;
                $display("FAIL held_no_edge: done=%b while ready only held high, want 0000", done_o);
            end
        end
        step(1);
        DDR3_rdy = 1'b0;
        step(1);
        DDR3_rdy = 1'b1; ddr_rdata_i = 32'h1234_5678;
        push_exp(4'b1000, 32'h1234_5678, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL held_done: no done_o, want 1000"); end
        step(1);
        req_i = '0; DDR3_rdy = 1'b0; DDR3_w_rdy = 1'b0;
        step(1);
    endtask

    task automatic test_fairness;
        logic [NR-1:0] g, nr, want;
        logic [AW-1:0] a;
        bit            ok;
        int            order[6];
        order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NR; i++) req_addr_i[i*AW +: AW] = 32'h1000 + i*16;
        req_we_i = '0;
        req_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            want = 4'(1 << order[k]);
            // last pass: requester 1 is already granted when it withdraws
            if (k == 5) req_i = '0;
            push_exp(want, 32'hF000_0000 + k, 1'b0);
            serve(2, 32'hF000_0000 + k, 1'b1, g, a, nr, ok);
            checks++;
            if (!ok || g !== want || a !== 32'h1000 + order[k]*16) begin
                errors++;
                $display("FAIL fair_grant%0d: ok=%0d grant=%b addr=%h, want grant=%b addr=%h",
                         k, ok, g, a, want, 32'h1000 + order[k]*16);
            end
            if (k < 5) begin
                checks++;
                if (nr !== 4'hF) begin
                    errors++;
                    $display("FAIL fair_nrdy%0d: n_rdy=%b want 1111", k, nr);
                end
            end
        end
        step(1);
    endtask

    task automatic test_single_read;
        logic [NR-1:0] g, nr;
        logic [AW-1:0] a;
        bit            ok;
        int            en0;
        req_we_i[0] = 1'b0; req_addr_i[0 +: AW] = 32'h100;
        req_i = 4'b0001;
        #1;
        checks++;
        if (n_rdy_o !== 4'b0001) begin
            errors++;
            $display("FAIL sr_nrdy_now: n_rdy=%b want 0001", n_rdy_o);
        end
        en0 = en_cnt;
        push_exp(4'b0001, 32'hDEAD_BEEF, 1'b0);
        serve(5, 32'hDEAD_BEEF, 1'b0, g, a, nr, ok);
        checks++;
        if (!ok || g !== 4'b0001 || a !== 32'h100 || nr !== 4'b0001) begin
            errors++;
            $display("FAIL sr_cmd: ok=%0d grant=%b addr=%h n_rdy=%b, want 0001/100/0001", ok, g, a, nr);
        end
        checks++;
        if (en_cnt - en0 !== 1) begin
            errors++;
            $display("FAIL sr_strobes: got %0d strobe cycles want 1", en_cnt - en0);
        end
        step(1);
        checks++;
        if (rdata_o !== 32'hDEAD_BEEF || grant_o !== '0 || done_o !== '0) begin
            errors++;
            $display("FAIL sr_after: rdata=%h grant=%b done=%b, want deadbeef/0000/0000", rdata_o, grant_o, done_o);
        end
    endtask

    task automatic test_wrong_ready;
        bit ok;
        req_we_i[1] = 1'b1; req_addr_i[1*AW +: AW] = 32'h200; req_wdata_i[1*DW +: DW] = 32'hA5A5_5A5A;
        req_i = 4'b0010;
        wait_en(ok);
        checks++;
        if (!ok || ddr_we_o !== 1'b1 || ddr_addr_o !== 32'h200 || ddr_wdata_o !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL wr_cmd: ok=%0d we=%b addr=%h wdata=%h, want 1/200/a5a55a5a",
                     ok, ddr_we_o, ddr_addr_o, ddr_wdata_o);
        end
        step(1);
        DDR3_rdy = 1'b1; ddr_rdata_i = 32'hBAD0_BAD0;
        step(1);
        DDR3_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done_o !== '0) begin
                errors++;
                $display("FAIL wr_ignore_rdy: done=%b after read-ready pulse, want 0000", done_o);
            end
        end
        step(1);
        DDR3_w_rdy = 1'b1;
        push_exp(4'b0010, 32'hDEAD_BEEF, 1'b0);
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_done: no done_o, want 0010"); end
        step(1);
        req_i = '0; DDR3_w_rdy = 1'b0;
        step(1);
    endtask

    task automatic test_same;
        logic [NR-1:0] g, nr;
        logic [AW-1:0] a;
        bit            ok;
        req_we_i = '0; req_addr_i[3*AW +: AW] = 32'h3300;
        req_same_i = 4'b0100;
        req_i = 4'b1100;
        #1;
        checks++;
        if (n_rdy_o !== 4'b1000) begin
            errors++;
            $display("FAIL same_nrdy: n_rdy=%b want 1000", n_rdy_o);
        end
        push_exp(4'b1000, 32'h3333_0003, 1'b0);
        serve(3, 32'h3333_0003, 1'b0, g, a, nr, ok);
        checks++;
        if (!ok || g !== 4'b1000 || a !== 32'h3300) begin
            errors++;
            $display("FAIL same_grant: ok=%0d grant=%b addr=%h, want 1000/3300", ok, g, a);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== '0 || n_rdy_o !== '0) begin
                errors++;
                $display("FAIL same_idle: grant=%b n_rdy=%b with only same-line request, want 0000/0000",
                         grant_o, n_rdy_o);
            end
        end
        step(1);
        req_i = '0; req_same_i = '0;
        step(1);
    endtask

    task automatic test_stall;
        logic [NR-1:0] g0;
        logic [AW-1:0] a0;
        bit            ok;
        req_we_i[0] = 1'b0; req_addr_i[0 +: AW] = 32'h500;
        req_i = 4'b0001;
        wait_en(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_issue: no strobe, want one"); end
        step(1);
        stall_i = 1'b1;
        @(negedge clk);
        g0 = grant_o; a0 = ddr_addr_o;
        step(1);
        DDR3_rdy = 1'b1; ddr_rdata_i = 32'h5555_AAAA;
        push_exp(4'b0001, 32'h5555_AAAA, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== g0 || ddr_addr_o !== a0 || done_o !== '0 || ddr_en_o !== 1'b0 || g0 !== 4'b0001) begin
                errors++;
                $display("FAIL stall_frozen: grant=%b addr=%h done=%b en=%b, want 0001/500/0000/0",
                         grant_o, ddr_addr_o, done_o, ddr_en_o);
            end
        end
        step(1);
        stall_i = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_resume: no done_o after stall, want 0001"); end
        step(1);
        req_i = '0; DDR3_rdy = 1'b0;
        step(1);
    endtask

    task automatic test_timeout;
        logic [NR-1:0] g, nr;
        logic [AW-1:0] a;
        bit            ok;
        int            n;
        // edge on the very last WAIT cycle still counts as a completion
        req_addr_i[2*AW +: AW] = 32'h300;
        req_i = 4'b0100;
        push_exp(4'b0100, 32'h7777_0007, 1'b0);
        serve(TO - 1, 32'h7777_0007, 1'b0, g, a, nr, ok);
        checks++;
        if (!ok || err_o !== 1'b0) begin
            errors++;
            $display("FAIL to_edge_at_limit: ok=%0d err=%b, want done with err=0", ok, err_o);
        end
        step(1);
        req_i = 4'b0100;
        push_exp(4'b0100, 32'h7777_0007, 1'b1);
        wait_en(ok);
        n = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (done_o !== '0) ok = 1'b1;
        end
        checks++;
        if (!ok || n !== TO) begin
            errors++;
            $display("FAIL to_latency: ok=%0d done %0d cycles after strobe, want %0d", ok, n, TO);
        end
        step(1);
        req_i = '0;
        step(3);
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: err=%b want 1", err_o);
        end
        step(1);
    endtask

    task automatic test_reset_mid;
        bit ok;
        req_we_i[1] = 1'b0; req_addr_i[1*AW +: AW] = 32'h600;
        req_i = 4'b0010;
        wait_en(ok);
        step(1);
        reset = 1'b1; req_i = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (!ok || {grant_o, done_o, ddr_en_o, ddr_we_o, err_o, n_rdy_o} !== '0 ||
            ddr_addr_o !== '0 || ddr_wdata_o !== '0 || rdata_o !== '0) begin
            errors++;
            $display("FAIL rst_mid: ok=%0d grant=%b done=%b en=%b err=%b addr=%h wdata=%h rdata=%h, want all 0",
                     ok, grant_o, done_o, ddr_en_o, err_o, ddr_addr_o, ddr_wdata_o, rdata_o);
        end
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done_o !== '0) begin
                errors++;
                $display("FAIL rst_mid_no_done: done=%b after abandoned transaction, want 0000", done_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_held_ready();
        test_fairness();
        test_single_read();
        test_wrong_ready();
        test_same();
        test_stall();
        test_timeout();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected completions never seen, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

Round-robin arbiter and sequencer that shares the single DDR3 controller port between `NUM_REQ` load/store-unit requesters of the GPGPU core. It grants one requester at a time and drives the DDR3 command for one cycle. It then waits for the read- or write-ready rising edge, returns read data, and holds every waiting requester off with a per-requester not-ready stall. It sits between the LSU output stage and the DDR3 user interface and replaces per-LSU stall handshakes.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `ADDR_W`, 32: DDR3 address width
- `DATA_W`, 32: data width
- `TIMEOUT_CYC`, 1023: maximum non-stalled WAIT cycles before abort; ≥ 2
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `stall_i` in 1: global pipeline stall; freezes all state
- `req_i` in NUM_REQ: request valid per requester; held until `done_o`
- `req_we_i` in NUM_REQ: 1 = write, 0 = read
- `req_same_i` in NUM_REQ: access served locally (same line); request ignored
- `req_addr_i` in NUM_REQ*ADDR_W: packed, requester i at [i*ADDR_W +: ADDR_W]
- `req_wdata_i` in NUM_REQ*DATA_W: packed likewise
- `grant_o` out NUM_REQ: one-hot owner, registered
- `n_rdy_o` out NUM_REQ: requester must stall
- `done_o` out NUM_REQ: one-cycle completion pulse, registered
- `rdata_o` out DATA_W: read data, valid with `done_o`, held until next read completes
- `err_o` out 1: sticky timeout flag, cleared only by reset
- `ddr_en_o` out 1: command strobe, one cycle per transaction
- `ddr_we_o`, `ddr_addr_o`, `ddr_wdata_o` out 1/ADDR_W/DATA_W: command fields, stable from ISSUE to return to IDLE
- `DDR3_rdy` in 1: read completion; rising edge = read data valid
- `DDR3_w_rdy` in 1: write completion; rising edge = write accepted
- `ddr_rdata_i` in DATA_W: read data

## Operation
- Eligible requester: `req_i[i] & ~req_same_i[i] & ~done_o[i]`.
- `n_rdy_o[i]` is combinational and equals eligible. It is high the same cycle a request appears.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE when any requester is eligible.
  - Winner is the first eligible index scanning upward from `last+1`, modulo NUM_REQ.
  - Register `grant_o`, `last`, and the command fields from the winner.
- ISSUE → WAIT: `ddr_en_o` = 1 for exactly this cycle; clear the timeout counter.
- WAIT → DONE on a rising edge of the selected ready: `DDR3_rdy` for a read, `DDR3_w_rdy` for a write.
  - Rising edge: `*_pre == 0 && input == 1`.
  - The other ready line is ignored.
  - On a read, latch `ddr_rdata_i` into `rdata_o`.
- WAIT → DONE also when the counter reaches TIMEOUT_CYC-1 with no edge. This sets `err_o`; `rdata_o` is unchanged.
- DONE → IDLE: `done_o[grant]` = 1 for one cycle; `grant_o` clears.
- If the requester drops `req_i` while granted, the transaction still completes and `done_o` still pulses.
- `req_same_i` asserted in any state never cancels a granted transaction.
- `DDR3_rdy_pre`/`DDR3_w_rdy_pre` update every non-stalled cycle in all states. They reset to 1, so a ready already high at reset is not an edge.

## Timing
- Reset values:
  - state IDLE
  - `grant_o`, `done_o`, `ddr_en_o`, `ddr_we_o`, `err_o` = 0
  - `ddr_addr_o`, `ddr_wdata_o`, `rdata_o` = 0
  - `last` = NUM_REQ-1, so requester 0 wins first
  - timeout counter = 0
  - `*_pre` = 1
- Reset mid-transaction abandons it; no `done_o` is produced.
- `stall_i` = 1 freezes state, counter, `last`, `*_pre`, and all registered outputs, including a pending `done_o` pulse (it lasts through the stall plus one cycle).
  - `ddr_en_o` is also held, and the DDR3 side must tolerate a repeated strobe.
  - Ready edges occurring during a stall are missed; the DDR3 side holds ready high until serviced.
- Latency, no stall: request at cycle 0 → grant at 1, `ddr_en_o` at 2 → edge seen at cycle E ≥ 3 → `done_o` at E+1.
  - Back-to-back: the next grant is at E+2.
- An edge in the same cycle as the timeout limit is treated as a completion; `err_o` is not set.
- Counter width is `$clog2(TIMEOUT_CYC)`. It saturates and never wraps.

## Structure
- Shared package `ddr3_arb_pkg`: state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and `DDR3_ARB_MAX_REQ` = 8.
- One sub-module, `rr_picker`: combinational round-robin select from (eligible vector, `last`) to one-hot plus index. It is reused elsewhere for warp scheduling.
- The rest (FSM, edge detect, timeout, muxes) stays flat in `ddr3_port_arbiter`.

## Test plan
- Single read: req0 read at addr 0x100, `DDR3_rdy` rises 5 cycles after `ddr_en_o` with data 0xDEADBEEF → one strobe with addr 0x100, `done_o` = 0001, `rdata_o` = 0xDEADBEEF; `n_rdy_o[0]` high from cycle 0 until done.
- Fairness: all 4 requesters request continuously → grant order 0,1,2,3,0 with no starvation; non-granted `n_rdy_o` stay high.
- Wrong-ready filtering: write pending, `DDR3_rdy` pulses → ignored; `DDR3_w_rdy` rises → done. Ready high through reset, then held → no completion until it toggles low→high.
- Timeout: TIMEOUT_CYC = 8, no ready edge → `done_o` pulses 8 WAIT cycles after ISSUE; `err_o` = 1 and stays set.
- Stall/same/reset: `stall_i` for 3 cycles during WAIT → outputs frozen, then resumes. `req_same_i[2]` with `req_i[2]` → never granted, `n_rdy_o[2]` = 0. `reset` in WAIT → all outputs 0 next cycle.
